cpu_datapath: RTL

- Register-and-ALU datapath of the 8-bit CPU; the responder to control_unit.
- Consumes every control_unit output each cycle and updates PC, IR, A, B, ALU_OUT, MDR and ZF.
- Returns instr and zf to control_unit.
- Drives an external byte-wide memory that has combinational read and synchronous write.

---
 rtl/cpu_datapath_if.sv | 50 +++++
 rtl/cpu_datapath.sv | 79 +++++++
 2 files changed

// File: rtl/cpu_datapath_if.sv
// Control, memory and debug bundle between control_unit/memory (master) and the datapath (slave).
// Pure wiring, no state; no backpressure, every signal is sampled every cycle.
interface cpu_datapath_if;
  logic        pc_we;
  logic        pc_sel;
  logic        pc_jmp_sel;
  logic [3:0]  pc_offset;
  logic        addr_sel;
  logic [3:0]  addr_offset;
  logic        mem_sel;
  logic        mem_we;
  logic [2:0]  alu_opcode;
  logic        alu_sel_a;
  logic        alu_sel_b;
  logic        alu_we;
  logic        zf_we;
  logic        ir_we;
  logic        a_sel;
  logic        a_we;
  logic        b_sel;
  logic        b_we;
  logic        halt;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wen;
  logic [7:0]  mem_rdata;
  logic [7:0]  instr;
  logic        zf;
  logic        halted;
  logic [7:0]  pc_out;
  logic [7:0]  a_out;
  logic [7:0]  b_out;
  logic [15:0] retired;

  modport master (
    output pc_we, pc_sel, pc_jmp_sel, pc_offset, addr_sel, addr_offset,
           mem_sel, mem_we, alu_opcode, alu_sel_a, alu_sel_b, alu_we, zf_we,
           ir_we, a_sel, a_we, b_sel, b_we, halt, mem_rdata,
    input  mem_addr, mem_wdata, mem_wen, instr, zf, halted,
           pc_out, a_out, b_out, retired
  );

  modport slave (
    input  pc_we, pc_sel, pc_jmp_sel, pc_offset, addr_sel, addr_offset,
           mem_sel, mem_we, alu_opcode, alu_sel_a, alu_sel_b, alu_we, zf_we,
           ir_we, a_sel, a_we, b_sel, b_we, halt, mem_rdata,
    output mem_addr, mem_wdata, mem_wen, instr, zf, halted,
           pc_out, a_out, b_out, retired
  );
endinterface

// File: rtl/cpu_datapath.sv
// 8-bit CPU register/ALU datapath; registers update one edge after the control request.
// No backpressure: controls are obeyed every cycle until halted, then everything freezes until reset.
module cpu_datapath #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic          clk,
  input  logic          reset_n,
  cpu_datapath_if.slave bus
);

  logic [7:0]  pc, ir, a, b, alu_out, mdr;
  logic        zf_q, halted_q;
  logic [15:0] retired_q;

  logic [7:0]  alu_x, alu_y, alu_res, pc_next, pc_rel;

  assign alu_x = bus.alu_sel_a ? b : a;
  assign alu_y = bus.alu_sel_b ? a : b;

  always_comb begin
    alu_res = 8'h00;
    case (bus.alu_opcode)
      3'b000:  alu_res = alu_x + alu_y;
      3'b001:  alu_res = alu_x & alu_y;
      3'b010:  alu_res = ~alu_x;
      3'b011:  alu_res = alu_x - alu_y;
      3'b100:  alu_res = alu_x;
      default: alu_res = 8'h00;
    endcase
  end

  assign pc_rel = pc + {{4{bus.pc_offset[3]}}, bus.pc_offset};

  always_comb begin
    pc_next = pc + 8'd1;
    if (bus.pc_sel) begin
      pc_next = bus.pc_jmp_sel ? {4'h0, bus.pc_offset} : pc_rel;
    end
  end

  assign bus.mem_addr  = bus.addr_sel ? {4'h0, bus.addr_offset} : pc;
  assign bus.mem_wdata = bus.mem_sel ? b : a;
  assign bus.mem_wen   = bus.mem_we & ~halted_q;
  assign bus.instr     = ir;
  assign bus.zf        = zf_q;
  assign bus.halted    = halted_q;
  assign bus.pc_out    = pc;
  assign bus.a_out     = a;
  assign bus.b_out     = b;
  assign bus.retired   = retired_q;

  // All sources are pre-edge values, so A/B swaps and ALU_OUT read-while-write behave as old-value reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= PC_RESET;
      ir        <= 8'h00;
      a         <= 8'h00;
      b         <= 8'h00;
      alu_out   <= 8'h00;
      mdr       <= 8'h00;
      zf_q      <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= 16'h0000;
    end else if (!halted_q) begin
      mdr <= bus.mem_rdata;
      if (bus.pc_we)  pc      <= pc_next;
      if (bus.alu_we) alu_out <= alu_res;
      if (bus.zf_we)  zf_q    <= (alu_res == 8'h00);
      if (bus.a_we)   a       <= bus.a_sel ? alu_out : mdr;
      if (bus.b_we)   b       <= bus.b_sel ? alu_out : mdr;
      if (bus.ir_we) begin
        ir <= bus.mem_rdata;
        if (retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
      end
      if (bus.halt)   halted_q <= 1'b1;
    end
  end

endmodule
